// File: rtl/spi_sector_reader.sv
// SPI NOR sector reader: streams len_sector sectors into memory over Avalon-MM.
// Define SPI_SECTOR_READER_FASTREAD_EN for FAST_READ (0x0B) with 8 dummy clocks.
module spi_sector_reader #(
  parameter int          SECTOR_BYTES = 512,
  parameter int          CLK_DIV      = 2,
  parameter logic [7:0]  CMD_READ     = 8'h03
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] startaddr,
  input  logic [15:0] sector,
  input  logic [15:0] len_sector,
  output logic        spi_sck,
  output logic        spi_cs_n,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic [31:0] avm_m0_address,
  output logic        avm_m0_write,
  output logic [31:0] avm_m0_writedata,
  input  logic        avm_m0_waitrequest,
  output logic        busy,
  output logic        done
);

  localparam int SHIFT = $clog2(SECTOR_BYTES);
  localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

`ifdef SPI_SECTOR_READER_FASTREAD_EN
  localparam logic [7:0] OPCODE   = 8'h0B;
  localparam int         HDR_BITS = 40;
`else
  localparam logic [7:0] OPCODE   = CMD_READ;
  localparam int         HDR_BITS = 32;
`endif
  localparam logic [5:0] HDR_LAST = 6'(HDR_BITS - 1);

  typedef enum logic [2:0] {
    IDLE, CMD, DATA, WRITE, DONE
  } state_t;

  state_t state, state_nx;

  logic          sck;
  logic [DW-1:0] div_cnt;
  logic [5:0]    bit_cnt;
  logic [39:0]   cmd_sr;
  logic [6:0]    byte_sr;
  logic [31:0]   byte_count;
  logic [31:0]   sec_bytes;
  logic          shifting;
  logic          phase_end;
  logic          rise;
  logic          fall;
  logic          unused_bits;

  assign sec_bytes   = 32'(sector) << SHIFT;
  assign unused_bits = ^{startaddr[1:0], sec_bytes[31:24]};

  assign shifting  = (state == CMD) || (state == DATA);
  assign phase_end = (div_cnt == DIV_MAX);
  assign rise      = shifting && phase_end && !sck;
  assign fall      = shifting && phase_end && sck;
  assign spi_sck   = sck;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start)
          state_nx = (len_sector == 16'd0) ? DONE : CMD;
      end
      CMD: begin
        if (fall && bit_cnt == HDR_LAST)
          state_nx = DATA;
      end
      DATA: begin
        if (fall && bit_cnt == 6'd31)
          state_nx = WRITE;
      end
      WRITE: begin
        if (!avm_m0_waitrequest)
          state_nx = (byte_count == 32'd4) ? DONE : DATA;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    spi_cs_n     = 1'b1;
    spi_mosi     = 1'b0;
    avm_m0_write = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    unique case (state)
      IDLE: ;
      CMD: begin
        spi_cs_n = 1'b0;
        spi_mosi = cmd_sr[39];
        busy     = 1'b1;
      end
      DATA: begin
        spi_cs_n = 1'b0;
        busy     = 1'b1;
      end
      WRITE: begin
        spi_cs_n     = 1'b0;
        avm_m0_write = 1'b1;
        busy         = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck              <= 1'b0;
      div_cnt          <= '0;
      bit_cnt          <= '0;
      cmd_sr           <= '0;
      byte_sr          <= '0;
      byte_count       <= '0;
      avm_m0_address   <= '0;
      avm_m0_writedata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          sck     <= 1'b0;
          div_cnt <= '0;
          bit_cnt <= '0;
          if (start) begin
            // trailing zeros double as the fast-read dummy byte
            cmd_sr         <= {OPCODE, sec_bytes[23:0], 8'h00};
            byte_count     <= 32'(len_sector) << SHIFT;
            avm_m0_address <= {startaddr[31:2], 2'b00};
          end
        end
        CMD, DATA: begin
          if (phase_end) begin
            div_cnt <= '0;
            sck     <= ~sck;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
          if (rise && state == DATA) begin
            byte_sr <= {byte_sr[5:0], spi_miso};
            if (bit_cnt[2:0] == 3'd7)
              avm_m0_writedata[{bit_cnt[4:3], 3'b000} +: 8] <=
                {byte_sr, spi_miso};
          end
          if (fall) begin
            if (state == CMD)
              cmd_sr <= {cmd_sr[38:0], 1'b0};
            if ((state == CMD && bit_cnt == HDR_LAST) ||
                (state == DATA && bit_cnt == 6'd31))
              bit_cnt <= '0;
            else
              bit_cnt <= bit_cnt + 6'd1;
          end
        end
        WRITE: begin
          if (!avm_m0_waitrequest) begin
            avm_m0_address <= avm_m0_address + 32'd4;
            byte_count     <= byte_count - 32'd4;
          end
        end
        DONE: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_sector_reader.sv
// Directed bench for spi_sector_reader with flash, memory and SCK timing models.
module tb_spi_sector_reader;

`ifdef SPI_SECTOR_READER_FASTREAD_EN
  localparam logic [7:0] OPC = 8'h0B;
  localparam int         HDR = 40;
`else
  localparam logic [7:0] OPC = 8'h03;
  localparam int         HDR = 32;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] startaddr = '0;
  logic [15:0] sector = '0;
  logic [15:0] len_sector = '0;
  logic        spi_sck, spi_cs_n, spi_mosi;
  logic        spi_miso = 1'b0;
  logic [31:0] avm_m0_address, avm_m0_writedata;
  logic        avm_m0_write;
  logic        avm_m0_waitrequest = 1'b0;
  logic        busy, done;

  logic        s_rst = 1'b1;
  logic        s_start = 1'b0;
  logic        s_sck, s_cs_n, s_mosi, s_write, s_busy, s_done;
  logic [31:0] s_addr, s_wdata;

  always #5 clk = ~clk;

  spi_sector_reader #(.SECTOR_BYTES(512), .CLK_DIV(1)) u_dut (
    .clk(clk), .rst(rst), .start(start),
    .startaddr(startaddr), .sector(sector), .len_sector(len_sector),
    .spi_sck(spi_sck), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .avm_m0_address(avm_m0_address), .avm_m0_write(avm_m0_write),
    .avm_m0_writedata(avm_m0_writedata),
    .avm_m0_waitrequest(avm_m0_waitrequest),
    .busy(busy), .done(done)
  );

  spi_sector_reader #(.SECTOR_BYTES(512), .CLK_DIV(3)) u_slow (
    .clk(clk), .rst(s_rst), .start(s_start),
    .startaddr(startaddr), .sector(sector), .len_sector(len_sector),
    .spi_sck(s_sck), .spi_cs_n(s_cs_n),
    .spi_mosi(s_mosi), .spi_miso(1'b0),
    .avm_m0_address(s_addr), .avm_m0_write(s_write),
    .avm_m0_writedata(s_wdata), .avm_m0_waitrequest(1'b0),
    .busy(s_busy), .done(s_done)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // flash: returns (address & 0xFF) for each byte after the header
  int          n_rise;
  int          cs_fall;
  logic [31:0] cmd_cap;

  always @(negedge spi_cs_n) begin
    n_rise  = 0;
    cmd_cap = '0;
    cs_fall++;
  end

  always @(posedge spi_sck) begin
    if (!spi_cs_n) begin
      if (n_rise < 32) cmd_cap = {cmd_cap[30:0], spi_mosi};
      n_rise++;
    end
  end

  always @(negedge spi_sck) begin
    int d;
    logic [7:0] b;
    if (!spi_cs_n && n_rise >= HDR) begin
      d = n_rise - HDR;
      b = cmd_cap[7:0] + 8'(d / 8);
      spi_miso = b[7 - (d % 8)];
    end
  end

  // memory with optional stall on every third write
  int          wcount;
  logic [31:0] wa [0:511];
  logic [31:0] wd [0:511];
  logic [31:0] ref_d [0:127];
  bit          stall_en = 1'b0;
  int          stalls = 0;
  int          stall_cycles = 0;
  int          stall_bad = 0;
  logic [31:0] hold_a, hold_d;
  int          done_cnt;
  int          cs_rise;

  always @(posedge spi_cs_n) cs_rise++;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (avm_m0_write && !rst) begin
      if (stall_en && (wcount % 3 == 2) && stalls < 5) begin
        if (stalls == 0) begin
          hold_a = avm_m0_address;
          hold_d = avm_m0_writedata;
        end else if (avm_m0_address !== hold_a ||
                     avm_m0_writedata !== hold_d) begin
          stall_bad++;
        end
        if (spi_sck !== 1'b0) stall_bad++;
        stalls++;
        stall_cycles++;
        avm_m0_waitrequest = 1'b1;
      end else begin
        if (stalls > 0 && (avm_m0_address !== hold_a ||
                           avm_m0_writedata !== hold_d))
          stall_bad++;
        if (wcount < 512) begin
          wa[wcount] = avm_m0_address;
          wd[wcount] = avm_m0_writedata;
        end
        wcount++;
        stalls = 0;
        avm_m0_waitrequest = 1'b0;
      end
    end else begin
      avm_m0_waitrequest = 1'b0;
    end
  end

  // SCK phase and MOSI setup monitor for the CLK_DIV=3 instance
  logic prev_sck = 1'b0;
  logic prev_mosi = 1'b0;
  int   run_len = 0;
  int   mosi_age = 0;
  int   s_rises = 0;
  int   bad_hi = 0;
  int   bad_lo = 0;
  int   bad_setup = 0;

  always @(negedge clk) begin
    if (s_cs_n) begin
      run_len = 0;
    end else if (s_rises < 40) begin
      if (run_len > 0 && s_sck !== prev_sck) begin
        if (prev_sck) begin
          if (run_len != 3) bad_hi++;
        end else begin
          if (run_len != 3) bad_lo++;
          if (mosi_age < 3) bad_setup++;
          s_rises++;
        end
        run_len = 1;
      end else begin
        run_len++;
      end
    end
    if (s_mosi !== prev_mosi) mosi_age = 1;
    else mosi_age++;
    prev_sck  = s_sck;
    prev_mosi = s_mosi;
  end

  function automatic logic [31:0] exp_word(input logic [7:0] b0,
                                           input int j);
    logic [7:0] b;
    b = b0 + 8'(4 * j);
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  task automatic kick(input logic [31:0] sa, input logic [15:0] sec,
                      input logic [15:0] len);
    wcount   = 0;
    done_cnt = 0;
    cs_rise  = 0;
    cs_fall  = 0;
    @(negedge clk);
    startaddr  = sa;
    sector     = sec;
    len_sector = len;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int i;
    for (i = 0; i < budget && done !== 1'b1; i++) @(negedge clk);
    check(tag, done, 1'b1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_writes(input string tag, input int n,
                             input int budget);
    int i;
    for (i = 0; i < budget && wcount < n; i++) @(negedge clk);
    check(tag, 32'(wcount >= n), 1);
  endtask

  task automatic count_bad(input logic [31:0] base, input int n,
                           output int bad);
    bad = 0;
    for (int j = 0; j < n; j++)
      if (wa[j] !== base + 32'(4 * j) || wd[j] !== exp_word(8'h00, j))
        bad++;
  endtask

  initial begin
    int bad;
    int wsave;
    repeat (3) @(negedge clk);
    check("rst_ctrl", {spi_sck, spi_cs_n, spi_mosi, avm_m0_write,
                       busy, done}, 6'b010000);
    check("rst_addr", avm_m0_address, 32'h0);
    check("rst_data", avm_m0_writedata, 32'h0);
    rst   = 1'b0;
    s_rst = 1'b0;
    repeat (2) @(negedge clk);

    // single sector
    kick(32'h0000_1000, 16'd2, 16'd1);
    wait_done("t1_done", 20000);
    check("t1_cmd", cmd_cap, {OPC, 24'h000400});
    check("t1_count", wcount, 128);
    check("t1_first_addr", wa[0], 32'h0000_1000);
    check("t1_last_addr", wa[127], 32'h0000_11FC);
    check("t1_first_word", wd[0], 32'h0302_0100);
    count_bad(32'h0000_1000, 128, bad);
    check("t1_words", bad, 0);
    check("t1_done_cnt", done_cnt, 1);
    check("t1_cs_rise", cs_rise, 1);
    for (int j = 0; j < 128; j++) ref_d[j] = wd[j];

    // zero length
    kick(32'h0000_3000, 16'd4, 16'd0);
    check("t2_done", done, 1'b1);
    check("t2_busy", busy, 1'b0);
    check("t2_cs", spi_cs_n, 1'b1);
    @(negedge clk);
    check("t2_done_low", done, 1'b0);
    repeat (20) @(negedge clk);
    check("t2_writes", wcount, 0);
    check("t2_cs_fall", cs_fall, 0);

    // backpressure plus an ignored second start
    stall_en = 1'b1;
    kick(32'h0000_1000, 16'd2, 16'd1);
    wait_writes("t3_progress", 10, 5000);
    check("t3_busy", busy, 1'b1);
    startaddr  = 32'h0000_8000;
    sector     = 16'd7;
    len_sector = 16'd3;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("t3_done", 20000);
    repeat (50) @(negedge clk);
    stall_en = 1'b0;
    check("t3_count", wcount, 128);
    check("t3_stall_cycles", stall_cycles, 210);
    check("t3_stall_stable", stall_bad, 0);
    bad = 0;
    for (int j = 0; j < 128; j++)
      if (wd[j] !== ref_d[j] || wa[j] !== 32'h1000 + 32'(4 * j)) bad++;
    check("t3_same_data", bad, 0);
    check("t3_done_cnt", done_cnt, 1);

    // reset abort mid-DATA
    kick(32'h0000_2000, 16'd1, 16'd1);
    wait_writes("t4_progress", 5, 5000);
    repeat (20) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t4_rst_ctrl", {spi_sck, spi_cs_n, spi_mosi, avm_m0_write,
                          busy, done}, 6'b010000);
    check("t4_rst_addr", avm_m0_address, 32'h0);
    check("t4_rst_data", avm_m0_writedata, 32'h0);
    repeat (3) @(negedge clk);
    rst   = 1'b0;
    wsave = wcount;
    repeat (300) @(negedge clk);
    check("t4_no_writes", wcount, wsave);
    check("t4_no_done", done_cnt, 0);

    // multi-sector with destination wrap
    kick(32'hFFFF_FE00, 16'hFFFF, 16'd2);
    wait_done("t5_done", 40000);
    check("t5_cmd", cmd_cap, {OPC, 24'hFFFE00});
    check("t5_count", wcount, 256);
    check("t5_addr_top", wa[127], 32'hFFFF_FFFC);
    check("t5_addr_wrap", wa[128], 32'h0000_0000);
    count_bad(32'hFFFF_FE00, 256, bad);
    check("t5_words", bad, 0);
    check("t5_done_cnt", done_cnt, 1);

    // SCK timing at CLK_DIV=3
    @(negedge clk);
    startaddr  = 32'h0;
    sector     = 16'd0;
    len_sector = 16'd1;
    s_start    = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    for (int i = 0; i < 2000 && s_rises < 40; i++) @(negedge clk);
    check("t6_rises", 32'(s_rises >= 40), 1);
    check("t6_high_phase", bad_hi, 0);
    check("t6_low_phase", bad_lo, 0);
    check("t6_mosi_setup", bad_setup, 0);
    s_rst = 1'b1;
    repeat (2) @(negedge clk);
    s_rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
